// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time
// and buffers returned words with their PCs for decode.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_encoding,
    output logic [31:0]            inst_pc,
    output logic [$clog2(DEPTH):0] queue_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] { IDLE, WAIT, DISCARD } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, count_next;
    logic          push, pop;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    assign pop        = inst_valid & inst_ready;
    assign push       = (state_q == WAIT) & imem_ack & ~redirect_valid;
    assign count_next = count_q + CW'(push) - CW'(pop);

    // Next-state: redirect flushes the buffer; a live request is abandoned into DISCARD
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_next;
        end

        case (state_q)
            IDLE: begin
                if (!redirect_valid && (count_next < FULL)) state_d = WAIT;
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? WAIT : DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_next < FULL) ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        // DISCARD keeps presenting the abandoned address until its ack arrives
        addr_d = (state_d == DISCARD) ? addr_q : fetch_pc_d;
        req_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign inst_valid    = (count_q != '0);
    assign inst_encoding = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
    assign inst_pc       = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign queue_count   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_ack;
    logic [31:0]            imem_rdata;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [31:0]            inst_encoding;
    logic [31:0]            inst_pc;
    logic [$clog2(DEPTH):0] queue_count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_encoding  (inst_encoding),
        .inst_pc        (inst_pc),
        .queue_count    (queue_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: fetch PC, one optional outstanding request (live or stale), FIFO as a queue
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_stale;
    logic [63:0] mq[$];
    int          m_wait;

    // Memory stimulus controls
    int          lat;
    bit          rand_mem;
    bit          force_ack;
    logic [31:0] force_data;
    logic [31:0] mem_xor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fpc   = RESET_PC;
        m_addr  = RESET_PC;
        m_req   = 1'b0;
        m_stale = 1'b0;
        mq.delete();
    endtask

    task automatic model_step(input bit ack, input logic [31:0] rdata);
        bit pop;
        bit live_ack;
        if (!rst) begin
            model_reset();
            return;
        end
        pop      = (mq.size() != 0) && inst_ready;
        live_ack = m_req && !m_stale && ack;
        if (redirect_valid) begin
            mq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
            if (m_req) begin
                if (ack) begin
                    m_stale = 1'b0;
                    m_addr  = m_fpc;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (live_ack) begin
                mq.push_back({m_fpc, rdata});
                m_fpc = m_fpc + 32'd4;
            end
            if (m_req && m_stale) begin
                if (ack) begin
                    m_stale = 1'b0;
                    m_addr  = m_fpc;
                end
            end else if (m_req) begin
                if (ack) begin
                    if (mq.size() < DEPTH) m_addr = m_fpc;
                    else m_req = 1'b0;
                end
            end else if (mq.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_all();
        bit          e_v;
        logic [31:0] e_pc;
        logic [31:0] e_enc;
        e_v   = (mq.size() != 0);
        e_pc  = e_v ? mq[0][63:32] : 32'h0;
        e_enc = e_v ? mq[0][31:0]  : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("inst_valid", 32'(inst_valid), 32'(e_v));
        chk("inst_pc", inst_pc, e_pc);
        chk("inst_encoding", inst_encoding, e_enc);
        chk("queue_count", 32'(queue_count), 32'(mq.size()));
    endtask

    // One clock: drive memory response, advance model, then check after the edge
    task automatic tick();
        bit          a;
        logic [31:0] d;
        if (force_ack) begin
            a = 1'b1;
            d = force_data;
        end else if (rand_mem) begin
            a = ($urandom_range(0, 2) == 0);
            d = m_addr ^ mem_xor;
        end else begin
            a = m_req && (m_wait >= lat);
            d = m_addr ^ mem_xor;
        end
        imem_ack   = a;
        imem_rdata = d;
        model_step(a, d);
        @(posedge clk);
        #1;
        if (a || !m_req) m_wait = 0;
        else m_wait++;
        check_all();
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        lat = 0; rand_mem = 1'b0; force_ack = 1'b0; force_data = 32'h0;
        mem_xor = 32'h0; m_wait = 0;
        model_reset();

        // Reset values
        tick(); tick();
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_req", 32'(imem_req), 32'd0);

        // Free-run with zero-wait memory
        rst = 1'b1; inst_ready = 1'b1;
        tick();
        chk("edge0_req", 32'(imem_req), 32'd1);
        chk("edge0_addr", imem_addr, RESET_PC);
        tick();
        chk("edge1_valid", 32'(inst_valid), 32'd1);
        chk("edge1_pc", inst_pc, 32'h0);
        repeat (10) tick();
        chk("freerun_pc", inst_pc, 32'd40);
        chk("freerun_enc", inst_encoding, 32'd40);

        // Backpressure: fill, then a single pop
        rst = 1'b0; tick(); rst = 1'b1;
        inst_ready = 1'b0;
        repeat (5) tick();
        chk("bp_full_count", 32'(queue_count), 32'd4);
        chk("bp_full_req", 32'(imem_req), 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("bp_pop_pc", inst_pc, 32'h4);
        chk("bp_pop_req", 32'(imem_req), 32'd1);
        tick();
        chk("bp_refill_count", 32'(queue_count), 32'd4);
        inst_ready = 1'b1;
        repeat (6) tick();

        // Slow memory: ack three cycles after request
        lat = 3;
        repeat (16) tick();

        // Redirect while a request to 0x10 is outstanding
        rst = 1'b0; tick(); rst = 1'b1;
        lat = 0; inst_ready = 1'b1;
        repeat (5) tick();
        lat = 100;
        tick();
        chk("rd_pending_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(inst_valid), 32'd0);
        chk("rd_flush_count", 32'(queue_count), 32'd0);
        tick();
        force_ack = 1'b1; force_data = 32'hDEAD;
        tick();
        force_ack = 1'b0; lat = 0;
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_no_dead", inst_encoding, 32'h0);
        tick();
        chk("rd_first_pc", inst_pc, 32'h100);
        repeat (3) tick();

        // Redirect coincident with ack and pop, unaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("rc_valid", 32'(inst_valid), 32'd0);
        chk("rc_addr", imem_addr, 32'h200);
        tick();
        chk("rc_first_pc", inst_pc, 32'h200);

        // Reset while in WAIT with two entries queued
        rst = 1'b0; tick(); rst = 1'b1;
        inst_ready = 1'b0;
        repeat (3) tick();
        chk("mr_count", 32'(queue_count), 32'd2);
        rst = 1'b0;
        tick();
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, RESET_PC);
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_enc", inst_encoding, 32'h0);
        chk("mr_pc", inst_pc, 32'h0);
        chk("mr_count0", 32'(queue_count), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_restart_addr", imem_addr, RESET_PC);
        inst_ready = 1'b1;
        repeat (3) tick();

        // Random traffic including spurious acks, redirects and resets
        rand_mem = 1'b1;
        repeat (600) begin
            inst_ready     = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            rst            = !($urandom_range(0, 99) == 0);
            mem_xor        = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
